// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register file with write-through reads,
// immediate extension, and the ID/EX pipeline register.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrceE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    // Main decoder
    logic      reg_write;
    logic [1:0] result_src;
    logic      mem_write;
    logic      jump;
    logic      branch;
    logic      alu_src;
    imm_src_e  imm_src;
    alu_op_e   alu_op;

    always_comb begin
        reg_write  = 1'b0;
        result_src = 2'b00;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm_src    = IMM_J;
            end
            default: ;
        endcase
    end

    // ALU decoder; subtract on funct3=000 only for R-type (opcode bit 5 set) with funct7[5]
    alu_ctrl_e alu_ctrl;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
            IMM_J: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                              InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Register file; x0 is never written so it always reads zero
    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = RegWriteW && (RDW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en) begin
            regs[RDW] <= ResultW;
        end
    end

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    always_comb begin
        rd1 = (wr_en && (RDW == rs1)) ? ResultW : regs[rs1];
        rd2 = (wr_en && (RDW == rs2)) ? ResultW : regs[rs2];
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            ResultSrceE <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrceE <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= reg_write;
            ResultSrceE <= result_src;
            MemWriteE   <= mem_write;
            JumpE       <= jump;
            BranchE     <= branch;
            ALUControlE <= alu_ctrl;
            ALUSrcE     <= alu_src;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= imm_ext;
            Rs1E        <= rs1;
            Rs2E        <= rs2;
            RdE         <= rd;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed and randomised bench for decode_cycle: an independent decode model
// pushes expected ID/EX contents to a queue, popped after each clock edge.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        RegWriteE;
    logic [1:0]  ResultSrceE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    decode_cycle #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ResultSrceE(ResultSrceE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        j;
        logic        b;
        logic [2:0]  alu;
        logic        asrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic [31:0] pc = 32'h0000_1000;
    int          checks = 0;
    int          errors = 0;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic fl, input logic wen,
                                   input logic [4:0] wa, input logic [31:0] wd);
        exp_t       e;
        logic [1:0] isel;
        logic [1:0] aop;
        e = '0;
        if (fl) return e;
        isel = 2'd0;
        aop  = 2'd0;
        e.r1 = i[19:15];
        e.r2 = i[24:20];
        e.rd = i[11:7];
        e.rd1 = (wen && wa != 5'd0 && wa == e.r1) ? wd : mregs[e.r1];
        e.rd2 = (wen && wa != 5'd0 && wa == e.r2) ? wd : mregs[e.r2];
        case (i[6:0])
            7'b0000011: begin e.rw = 1; e.rsrc = 2'b01; e.asrc = 1; end
            7'b0100011: begin e.mw = 1; e.asrc = 1; isel = 2'd1; end
            7'b0110011: begin e.rw = 1; aop = 2'b10; end
            7'b0010011: begin e.rw = 1; e.asrc = 1; aop = 2'b10; end
            7'b1100011: begin e.b = 1; isel = 2'd2; aop = 2'b01; end
            7'b1101111: begin e.rw = 1; e.j = 1; e.rsrc = 2'b10; isel = 2'd3; end
            default: ;
        endcase
        if (aop == 2'b01) e.alu = 3'b001;
        else if (aop == 2'b10) begin
            if (i[14:12] == 3'b000)
                e.alu = (i[6:0] == 7'b0110011 && i[30]) ? 3'b001 : 3'b000;
            else if (i[14:12] == 3'b010) e.alu = 3'b101;
            else if (i[14:12] == 3'b110) e.alu = 3'b011;
            else if (i[14:12] == 3'b111) e.alu = 3'b010;
        end
        if (isel == 2'd0)      e.imm = {{20{i[31]}}, i[31:20]};
        else if (isel == 2'd1) e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        else if (isel == 2'd2) e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        else                   e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.pc  = p;
        e.pc4 = p + 32'd4;
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        cmp({tag, ".RegWriteE"}, 32'(RegWriteE), 32'(e.rw));
        cmp({tag, ".ResultSrceE"}, 32'(ResultSrceE), 32'(e.rsrc));
        cmp({tag, ".MemWriteE"}, 32'(MemWriteE), 32'(e.mw));
        cmp({tag, ".JumpE"}, 32'(JumpE), 32'(e.j));
        cmp({tag, ".BranchE"}, 32'(BranchE), 32'(e.b));
        cmp({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu));
        cmp({tag, ".ALUSrcE"}, 32'(ALUSrcE), 32'(e.asrc));
        cmp({tag, ".RD1E"}, RD1E, e.rd1);
        cmp({tag, ".RD2E"}, RD2E, e.rd2);
        cmp({tag, ".ImmExtE"}, ImmExtE, e.imm);
        cmp({tag, ".Rs1E"}, 32'(Rs1E), 32'(e.r1));
        cmp({tag, ".Rs2E"}, 32'(Rs2E), 32'(e.r2));
        cmp({tag, ".RdE"}, 32'(RdE), 32'(e.rd));
        cmp({tag, ".PCE"}, PCE, e.pc);
        cmp({tag, ".PCPlus4E"}, PCPlus4E, e.pc4);
    endtask

    // Drive one instruction (plus optional writeback), then check the ID/EX result
    task automatic step(input string tag, input logic [31:0] instr, input logic fl = 1'b0,
                        input logic wen = 1'b0, input logic [4:0] wa = 5'd0,
                        input logic [31:0] wd = 32'd0);
        exp_t e;
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        FlushE    = fl;
        RegWriteW = wen;
        RDW       = wa;
        ResultW   = wd;
        sb.push_back(model(instr, pc, fl, wen, wa, wd));
        @(posedge clk);
        if (wen && wa != 5'd0) mregs[wa] = wd;
        #1;
        e = sb.pop_front();
        compare_all(tag, e);
        pc = pc + 32'd4;
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [2:0] f3,
                                           input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ops [8];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0000000, 7'b1110011};
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
        rst = 1'b0; InstrD = 32'hFFC4A303; PCD = 32'h40; PCPlus4D = 32'h44;
        FlushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
        #3;
        compare_all("reset", '0);
        @(posedge clk); #1;
        compare_all("reset_edge", '0);
        rst = 1'b1;

        step("lw", 32'hFFC4A303);
        cmp("lw_imm_const", ImmExtE, 32'hFFFFFFFC);
        step("sw", 32'hFE44AE23);
        cmp("sw_imm_const", ImmExtE, 32'hFFFFFFFC);
        step("pre_x6", 32'h0000_0000, 1'b0, 1'b1, 5'd6, 32'h0000_00F0);
        step("pre_x7", 32'h0000_0000, 1'b0, 1'b1, 5'd7, 32'h0000_000F);
        step("or", 32'h00736233);
        cmp("or_rd1_const", RD1E, 32'h0000_00F0);
        cmp("or_alu_const", 32'(ALUControlE), 32'd3);
        step("and", r_type(7'h00, 5'd7, 5'd6, 3'b111, 5'd5));
        step("slt", r_type(7'h00, 5'd7, 5'd6, 3'b010, 5'd5));
        step("sub", r_type(7'h20, 5'd7, 5'd6, 3'b000, 5'd5));
        step("add", r_type(7'h00, 5'd7, 5'd6, 3'b000, 5'd5));
        step("sll_other", r_type(7'h00, 5'd7, 5'd6, 3'b001, 5'd5));
        step("addi_f7", 32'h4003_0313);
        step("beq", 32'hFE73_0EE3);
        step("jal", 32'h8000_00EF);
        step("nop_zero", 32'h0000_0000);
        step("wt_x6", 32'h00030313, 1'b0, 1'b1, 5'd6, 32'h12345678);
        cmp("wt_rd1_const", RD1E, 32'h12345678);
        step("wr_x0", 32'h00000313, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        cmp("wr_x0_rd1_const", RD1E, 32'd0);
        step("rd_x0", 32'h00000313);
        step("flush", 32'hFFC4A303, 1'b1, 1'b1, 5'd9, 32'h0000AAAA);
        cmp("flush_rw_const", 32'(RegWriteE), 32'd0);
        step("after_flush", 32'hFFC4A303);
        cmp("after_flush_rd1_const", RD1E, 32'h0000AAAA);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 7)];
            step("rand", ins, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom);
        end

        #2 rst = 1'b0;
        #1;
        compare_all("reset_async", '0);
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 1; k < 32; k += 2) begin
            step("read_clear", r_type(7'h00, 5'(k + 1), 5'(k), 3'b110, 5'd1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second stage of the 5-stage RV32I pipeline.
- Consumes the IF/ID outputs (InstrD, PCD, PCPlus4D) from the fetch stage.
- Decodes the instruction, reads the 32x32 register file, sign-extends the immediate, and registers everything into the ID/EX pipeline register for execute.
- Owns the architectural register file; the writeback stage writes it through the W-side port.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, register count (5-bit index)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  synchronous bubble insert into ID/EX
- RegWriteE  out  1  register write enable
- ResultSrceE  out  2  result select: 00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1  store enable
- JumpE  out  1  jal
- BranchE  out  1  beq
- ALUControlE  out  3  ALU operation code
- ALUSrcE  out  1  ALU B-operand select: 1 = immediate
- RD1E  out  32  rs1 data
- RD2E  out  32  rs2 data
- ImmExtE  out  32  sign-extended immediate
- Rs1E  out  5  rs1 index
- Rs2E  out  5  rs2 index
- RdE  out  5  rd index
- PCE  out  32  PC
- PCPlus4E  out  32  PC+4

Behaviour:
- Reset (rst=0, async): every ID/EX output is 0 and all 32 registers are 0; this takes effect immediately, including mid-operation.
- Latency: decode is combinational from InstrD. All E outputs update on the next rising clk, so latency is 1 cycle.
- Register file write: on the rising clk when RegWriteW=1 and RDW!=0.
  - A write to x0 is ignored; x0 always reads 0.
- Register file read: combinational, with write-through.
  - If RegWriteW=1, RDW!=0 and RDW equals rs1 (or rs2), the read returns ResultW in the same cycle.
  - As a result, the same edge captures the new value in both the register file and RD1E/RD2E.
- Opcode decode:
  - lw 0000011: RegWrite=1, ResultSrc=01, ALUSrc=1, ImmSrc=I, ALUOp=00
  - sw 0100011: MemWrite=1, ALUSrc=1, ImmSrc=S, ALUOp=00
  - R-type 0110011: RegWrite=1, ALUOp=10
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, ImmSrc=I, ALUOp=10
  - beq 1100011: Branch=1, ImmSrc=B, ALUOp=01
  - jal 1101111: RegWrite=1, Jump=1, ResultSrc=10, ImmSrc=J
  - Any other opcode, including 0x00000000: all control bits 0 (NOP).
- ALU decode (ALUControl):
  - ALUOp=00: 000 (add)
  - ALUOp=01: 001 (sub)
  - ALUOp=10, by funct3:
    - 000: sub (001) only when R-type with funct7[5]=1, otherwise add (000)
    - 010: slt (101)
    - 110: or (011)
    - 111: and (010)
    - any other funct3: 000
- Immediate extension:
  - I: {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
- Field extraction: rs1=i[19:15], rs2=i[24:20], rd=i[11:7]. These are passed to E unchanged regardless of opcode.
- FlushE=1 at a clock edge:
  - RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE, ALUSrcE are loaded with 0; data/index outputs load 0.
  - Register file writes still occur on that edge.
- FlushE and reset together: reset dominates.

Test Plan:
- Reset: rst=0 after arbitrary traffic → all E outputs 0 immediately; release, then read x1..x31 → 0.
- Load decode: InstrD=FFC4A303 (lw x6,-4(x9)), one edge → RegWriteE=1, ResultSrcE=01, ALUSrcE=1, ALUControlE=000, ImmExtE=FFFFFFFC, Rs1E=9, RdE=6, MemWriteE=0.
- Store decode: InstrD=FE44AE23 (sw x4,-4(x9)) → MemWriteE=1, RegWriteE=0, ImmExtE=FFFFFFFC, Rs1E=9, Rs2E=4.
- R-type: preload x6=0x0F0, x7=0x00F, then InstrD=00736233 (or x4,x6,x7) → ALUControlE=011, RD1E=0xF0, RD2E=0x0F, RdE=4.
- Write-through: RegWriteW=1, RDW=6, ResultW=12345678 in the same cycle as InstrD=FFC4A303 reading... use 0x00030313 (addi x6,x6,0) → RD1E=12345678; write to RDW=0 → later read of x0 = 0.
- Flush: FlushE=1 with InstrD=FFC4A303 → all control outputs 0 next cycle; next edge with FlushE=0 decodes normally.
